shader_fetch: RTL
=================

# shader_fetch

Instruction fetch stage directly upstream of `shader_pipeline`. Owns the shader program counter, issues reads to the synchronous instruction memory, and presents fetched instructions with their PC to the decode/execute pipeline over a valid/ready handshake. A 2-entry output buffer absorbs the 1-cycle memory read latency so throughput stays at 1 instruction/cycle. Branch/jump redirects flush buffered and in-flight fetches.

## Interface
- `ADDR_W`, 8, instruction address width (word addressed)
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, PC loaded on reset

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `fetch_en`  in  1  permit new memory reads
- `imem_rd_en`  out  1  read strobe to instruction memory
- `imem_addr`  out  ADDR_W  read address (= `pc` when `imem_rd_en`)
- `imem_rdata`  in  INSTR_W  read data, valid the cycle after `imem_rd_en`
- `redirect_valid`  in  1  branch/jump taken, flush and restart
- `redirect_pc`  in  ADDR_W  restart address
- `out_valid`  out  1  buffer head holds an instruction
- `out_ready`  in  1  consumer accepts head this cycle
- `out_instr`  out  INSTR_W  head instruction
- `out_pc`  out  ADDR_W  PC of head instruction
- `pc`  out  ADDR_W  next address to fetch

## Operation
- State: `pc`, `inflight` (1 bit: read issued last cycle), `drop` (1 bit: discard returning data), 2-entry FIFO of {instr, pc}, `count` 0..2.
- FSM: IDLE (`fetch_en`=0, no issue) / RUN (`fetch_en`=1). Transitions purely on `fetch_en`; redirect acts in either state.
- Issue condition (combinational `imem_rd_en`): RUN && !`redirect_valid` && (`count` + `inflight` − pop) < 2, where pop = `out_valid` && `out_ready`.
- On issue: `pc` <= `pc` + 1 modulo 2^ADDR_W (0xFF wraps to 0x00 at ADDR_W=8); `inflight` <= 1, tagging PC = issued address.
- Return: when `inflight` && !`drop`, push {`imem_rdata`, tagged PC} into FIFO. If `drop`, discard and clear `drop`.
- Redirect (`redirect_valid`=1): pop this cycle still completes; remaining FIFO entries flushed (`count` <= 0); `pc` <= `redirect_pc`; if a read is in flight its data is dropped; no issue this cycle.
- Redirect while returning data arrives same cycle: data discarded.
- `fetch_en` deasserted: no new issue; in-flight read still lands; FIFO retained and drains normally.
- Simultaneous push and pop with `count`=2 cannot occur (issue rule guarantees space).
- FIFO never overflows; push with `count`=2 is an assertion failure in verification.

## Timing
- Reset values: `pc`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, `imem_rd_en`=0 during `rst`, `inflight`=0, `drop`=0, `count`=0, state IDLE.
- Reset mid-operation: all in-flight and buffered fetches lost, no output in the cycle after `rst` drops.
- Issue at cycle N → data on `imem_rdata` cycle N+1 → `out_valid` at cycle N+2.
- First instruction after reset release with `fetch_en`=1: issue cycle 0, `out_valid` cycle 2.
- Steady state with `out_ready`=1: one instruction per cycle, consecutive PCs.
- Redirect at cycle R: first issue of `redirect_pc` at R+1, valid at R+3 (2-bubble penalty).
- `out_instr`/`out_pc` stable while `out_valid` && !`out_ready`.

## Configuration
- `SHADER_FETCH_STALL_CNT_EN`: defined → adds output `stall_cycles` (32 bits, reset 0) incrementing each cycle `out_valid` && !`out_ready`, saturating at 0xFFFF_FFFF. Undefined → port and counter absent; all other behaviour identical.

## Test plan
- Reset, `fetch_en`=1, `out_ready`=1, memory word k = 0xA000_0000+k → `out_valid` first at cycle 2 with `out_pc`=0, `out_instr`=0xA000_0000; then PCs 1,2,3… every cycle.
- Hold `out_ready`=0 for 5 cycles from steady state → `count`=2, `imem_rd_en`=0, head unchanged; release → PCs continue with no gap or duplicate.
- Redirect to 0x40 while FIFO full and read in flight → no flushed PC ever appears; next valid `out_pc`=0x40 exactly 3 cycles after redirect.
- RESET_PC=0xFE, run 4 instructions → `out_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- Assert `rst` mid-stream with `count`=2 → next cycle `out_valid`=0, `pc`=RESET_PC; refetch resumes from RESET_PC.
- With `SHADER_FETCH_STALL_CNT_EN`, 7 back-pressured cycles with `out_valid`=1 → `stall_cycles`=7.

Source files
------------

// File: rtl/shader_fetch.sv
// Instruction fetch stage: PC, imem read issue and a 2-entry {instr, pc} output buffer.
// Optional build macro SHADER_FETCH_STALL_CNT_EN adds the stall_cycles back-pressure counter.
module shader_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
`ifdef SHADER_FETCH_STALL_CNT_EN
  output logic [31:0]        stall_cycles,
`endif
  output logic [ADDR_W-1:0]  pc
);

  typedef enum logic {IDLE, RUN} mode_t;

  mode_t              mode;
  logic               inflight;
  logic [ADDR_W-1:0]  tag_pc_p1;
  logic [INSTR_W-1:0] fifo_instr [2];
  logic [ADDR_W-1:0]  fifo_pc    [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               pop;
  logic               push;
  logic [2:0]         occupancy;

  // The mode follows fetch_en directly so the first issue lands in the cycle reset drops.
  assign mode      = fetch_en ? RUN : IDLE;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign occupancy = {1'b0, count} + {2'b00, inflight};

  assign imem_rd_en = !rst && (mode == RUN) && !redirect_valid &&
                      (occupancy < (3'd2 + {2'b00, pop}));
  assign imem_addr  = pc;

  // Issue is blocked during a redirect, so the only read that can be stale is the one
  // returning in the redirect cycle itself; it is discarded here rather than tracked.
  assign push = inflight && !redirect_valid;

  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // p0 -> p1: issue, PC advance and buffer occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= imem_rd_en;
      if (redirect_valid) begin
        pc     <= redirect_pc;
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (imem_rd_en) pc <= pc_inc(pc);
        if (push) wr_ptr <= ~wr_ptr;
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // p1 -> buffer: returning data paired with the address it was issued for
  always_ff @(posedge clk) begin
    if (imem_rd_en) tag_pc_p1 <= pc;
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= tag_pc_p1;
    end
  end

`ifdef SHADER_FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
